// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int DIV9600  = 326,
  parameter int DIV19200 = 163,
  parameter int DIV38400 = 81,
  parameter int DIV57600 = 54
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] select,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       parity_err
);

  // The 9600 divider is the largest, so it sizes the tick counter.
  localparam int DIV_W = $clog2(DIV9600 + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t           state_reg;
  logic             rx_meta_reg;
  logic             rx_s;
  logic             rx_prev_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_sel;
  logic [DIV_W-1:0] tick_cnt_reg;
  logic             tick;
  logic             start_edge;
  logic [3:0]       sample_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_reg;
`endif

  // Synchronizer flops power up as an idle (high) line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
      rx_prev_reg <= rx_s;
    end
  end

  // A start is only a falling edge, so a held-low line cannot retrigger.
  assign start_edge = (state_reg == IDLE) && rx_prev_reg && !rx_s;

  always_comb begin
    div_sel = DIV_W'(DIV9600);
    case (select)
      2'b00:   div_sel = DIV_W'(DIV9600);
      2'b01:   div_sel = DIV_W'(DIV19200);
      2'b10:   div_sel = DIV_W'(DIV38400);
      default: div_sel = DIV_W'(DIV57600);
    endcase
  end

  assign tick = (state_reg != IDLE) && (tick_cnt_reg == div_reg - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
      div_reg      <= DIV_W'(DIV9600);
    end else if (start_edge) begin
      tick_cnt_reg <= '0;
      div_reg      <= div_sel;
    end else if (state_reg == IDLE || tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      sample_cnt_reg <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      framing_err    <= 1'b0;
      overrun_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg    <= 1'b0;
      parity_err     <= 1'b0;
`endif
    end else begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            state_reg      <= START;
            sample_cnt_reg <= '0;
          end
        end

        START: begin
          if (tick) begin
            if (sample_cnt_reg == 4'd7) begin
              sample_cnt_reg <= '0;
              bit_idx_reg    <= '0;
              state_reg      <= rx_s ? IDLE : DATA;
            end else begin
              sample_cnt_reg <= sample_cnt_reg + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            sample_cnt_reg <= sample_cnt_reg + 4'd1;
            if (sample_cnt_reg == 4'd15) begin
              shift_reg[bit_idx_reg] <= rx_s;
              bit_idx_reg            <= bit_idx_reg + 3'd1;
              if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= STOP;
`endif
              end
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            sample_cnt_reg <= sample_cnt_reg + 4'd1;
            if (sample_cnt_reg == 4'd15) begin
              par_bit_reg <= rx_s;
              state_reg   <= STOP;
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            sample_cnt_reg <= sample_cnt_reg + 4'd1;
            if (sample_cnt_reg == 4'd15) begin
              state_reg <= IDLE;
              if (rx_s) begin
                // Overwrite on a full holding register; an accept in this clk is not an overrun.
                rx_data     <= shift_reg;
                rx_valid    <= 1'b1;
                overrun_err <= rx_valid && !rx_ready;
              end else begin
                framing_err <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              parity_err <= (^shift_reg) ^ par_bit_reg;
`endif
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, expected bytes and
// error-pulse counts are modelled in the bench and compared when the DUT presents data.
module tb_uart_rx;

  // Scaled-down dividers keep frames short; ratios between baud rates are preserved.
  localparam int D0 = 40;
  localparam int D1 = 20;
  localparam int D2 = 10;
  localparam int D3 = 7;
  localparam int TIMEOUT = 4000;

  logic       clk;
  logic       rst_n;
  logic [1:0] select;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       overrun_err;
  logic       parity_err;

  uart_rx #(
    .DIV9600(D0), .DIV19200(D1), .DIV38400(D2), .DIV57600(D3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .select(select), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .framing_err(framing_err), .overrun_err(overrun_err), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb_q[$];
  logic       model_pending = 1'b0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (framing_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (parity_err)  pe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  function automatic int bit_clks(input logic [1:0] sel);
    case (sel)
      2'b00:   return 16 * D0;
      2'b01:   return 16 * D1;
      2'b10:   return 16 * D2;
      default: return 16 * D3;
    endcase
  endfunction

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // sel_after is driven onto select right after the start bit; the frame must ignore it.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                            input logic [1:0] sel_after);
    int bc;
    bc = bit_clks(select);
    drive_bit(1'b0, bc);
    select = sel_after;
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, bc);
    if (par_flip) exp_pe++;
`endif
    drive_bit(stop_bit, bc);
    rx = 1'b1;
    if (stop_bit) begin
      if (model_pending) begin
        exp_ov++;
        void'(sb_q.pop_back());
      end
      sb_q.push_back(d);
      model_pending = 1'b1;
    end else begin
      exp_fe++;
    end
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_framing_cnt"}, fe_cnt, exp_fe);
    check_eq({tag, "_overrun_cnt"}, ov_cnt, exp_ov);
    check_eq({tag, "_parity_cnt"},  pe_cnt, exp_pe);
  endtask

  task automatic consume(input string tag);
    int n;
    logic [7:0] exp_byte;
    n = 0;
    while (!rx_valid && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, rx_valid, 1);
    check_eq({tag, "_sb_nonempty"}, (sb_q.size() > 0), 1);
    if (rx_valid && sb_q.size() > 0) begin
      exp_byte = sb_q.pop_front();
      check_eq({tag, "_data"}, rx_data, exp_byte);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check_eq({tag, "_valid_cleared"}, rx_valid, 0);
      model_pending = 1'b0;
    end
  endtask

  initial begin
    int bc;
    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    select = 2'b00;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_data", rx_data, 0);
    check_eq("rst_framing", framing_err, 0);
    check_eq("rst_overrun", overrun_err, 0);
    check_eq("rst_parity", parity_err, 0);
    rst_n = 1'b1;
    idle(4);

    // 0xA5 at select 00, select changed mid-frame
    select = 2'b00;
    send_frame(8'hA5, 1'b1, 1'b0, 2'b11);
    idle(8);
    check_counts("a5");
    consume("a5");

    // Back-to-back 0x3C, 0x81 without reading: overwrite and one overrun
    select = 2'b11;
    send_frame(8'h3C, 1'b1, 1'b0, 2'b11);
    send_frame(8'h81, 1'b1, 1'b0, 2'b11);
    idle(8);
    check_counts("ovr");
    consume("ovr");
    check_eq("ovr_sb_empty", sb_q.size(), 0);

    // Stop bit low: framing error, nothing delivered
    select = 2'b01;
    send_frame(8'h55, 1'b0, 1'b0, 2'b01);
    idle(2 * bit_clks(2'b01));
    check_eq("frm_valid", rx_valid, 0);
    check_counts("frm");

    // Short low glitch is rejected, then a real frame
    select = 2'b10;
    drive_bit(1'b0, 4 * D2);
    idle(3 * bit_clks(2'b10));
    check_eq("glitch_valid", rx_valid, 0);
    check_counts("glitch");
    send_frame(8'h0F, 1'b1, 1'b0, 2'b10);
    consume("x0f");

    // Reset during data bit 4, then 0xC3
    select = 2'b11;
    bc = bit_clks(2'b11);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 4; i++) drive_bit(i[0], bc);
    drive_bit(1'b0, bc / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_valid", rx_valid, 0);
    check_eq("midrst_data", rx_data, 0);
    rst_n = 1'b1;
    idle(2 * bc);
    check_eq("midrst_valid_after", rx_valid, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 2'b11);
    idle(4);
    check_counts("c3");
    consume("c3");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 2'b11);
    idle(4);
    check_counts("par_bad");
    consume("par_bad");
    send_frame(8'h07, 1'b1, 1'b0, 2'b11);
    idle(4);
    check_counts("par_good");
    consume("par_good");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
